// File: rtl/db9md_pkg.sv
// db9md_pkg: button/line bit indices, default timeout and cycle-state enum for the MD pad emulator
package db9md_pkg;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_Z     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_X     = 10;
    localparam int BTN_MODE  = 11;
    localparam int LINE_D0   = 0;
    localparam int LINE_D1   = 1;
    localparam int LINE_D2   = 2;
    localparam int LINE_D3   = 3;
    localparam int LINE_TL   = 4;
    localparam int LINE_TR   = 5;
    localparam int DEFAULT_TIMEOUT_CYC = 60000;
    typedef enum logic [2:0] {CYC_IDLE, CYC_ONE, CYC_TWO, CYC_ID, CYC_EXT} cyc_e;
endpackage

// File: rtl/db9md_pad_emu_if.sv
// db9md_pad_emu_if: host-facing pad bundle; sel_in/btn in, pad_out (active-low {TR,TL,D3..D0}) and cyc_dbg out
interface db9md_pad_emu_if;
    logic        sel_in;
    logic [11:0] btn;
    logic [5:0]  pad_out;
    logic [2:0]  cyc_dbg;
    modport master (output sel_in, btn, input pad_out, cyc_dbg);
    modport slave  (input sel_in, btn, output pad_out, cyc_dbg);
endinterface

// File: rtl/db9md_pad_emu_sync_edge.sv
// sync_edge: 2-FF synchroniser with preset, q = synced level, rise/fall = one-clk pulses
module sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic ff1_q, ff1_d, ff2_q, ff2_d, prev_q, prev_d;
    always_comb begin
        ff1_d  = d;
        ff2_d  = ff1_q;
        prev_d = ff2_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q  <= RST_VAL;
            ff2_q  <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            ff1_q  <= ff1_d;
            ff2_q  <= ff2_d;
            prev_q <= prev_d;
        end
    end
    assign q    = ff2_q;
    assign rise = ff2_q & ~prev_q;
    assign fall = ~ff2_q & prev_q;
endmodule

// File: rtl/db9md_pad_emu.sv
// db9md_pad_emu: Mega Drive 6/3-button pad responder; clk_sys/reset_n plain, pad bundle via slave modport
module db9md_pad_emu
    import db9md_pkg::*;
#(
    parameter bit SIX_BTN     = 1'b1,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int TW          = 16
) (
    input logic              clk_sys,
    input logic              reset_n,
    db9md_pad_emu_if.slave   pad
);
    logic          sel_s, sel_rise, sel_fall, sel_q, sel_d, timeout;
    cyc_e          cyc_q, cyc_d, cyc_base;
    logic [TW-1:0] timer_q, timer_d;
    logic [11:0]   btn_lat_q, btn_lat_d;
    logic [5:0]    pad_q, pad_d, lines;

    sync_edge #(.RST_VAL(1'b1)) u_sync (
        .clk  (clk_sys),
        .rst_n(reset_n),
        .d    (pad.sel_in),
        .q    (sel_s),
        .rise (sel_rise),
        .fall (sel_fall)
    );

    always_comb begin
        timeout   = timer_q == TW'(TIMEOUT_CYC);
        timer_d   = (sel_rise | sel_fall) ? '0 : timeout ? timer_q : timer_q + 1'b1;
        // expiry wins first, then a same-cycle falling edge advances from idle
        cyc_base  = timeout ? CYC_IDLE : cyc_q;
        cyc_d     = !SIX_BTN ? CYC_IDLE : !sel_fall ? cyc_base :
                    cyc_base == CYC_EXT ? CYC_ONE : cyc_e'(cyc_base + 3'd1);
        sel_d     = sel_s;
        btn_lat_d = cyc_q == CYC_IDLE ? pad.btn : btn_lat_q;
        // logical 1 = pressed / pin pulled low; inverted onto the pins below
        lines     = sel_q ? (cyc_q == CYC_ID ?
                        {btn_lat_q[BTN_C], btn_lat_q[BTN_B], btn_lat_q[BTN_MODE],
                         btn_lat_q[BTN_X], btn_lat_q[BTN_Y], btn_lat_q[BTN_Z]} :
                        {btn_lat_q[BTN_C], btn_lat_q[BTN_B], btn_lat_q[BTN_RIGHT],
                         btn_lat_q[BTN_LEFT], btn_lat_q[BTN_DOWN], btn_lat_q[BTN_UP]}) :
                    {btn_lat_q[BTN_START], btn_lat_q[BTN_A],
                     cyc_q == CYC_ID ? 4'hF : cyc_q == CYC_EXT ? 4'h0 :
                     {2'b11, btn_lat_q[BTN_DOWN], btn_lat_q[BTN_UP]}};
        pad_d     = ~lines;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sel_q     <= 1'b1;
            cyc_q     <= CYC_IDLE;
            timer_q   <= '0;
            btn_lat_q <= '0;
            pad_q     <= 6'b111111;
        end else begin
            sel_q     <= sel_d;
            cyc_q     <= cyc_d;
            timer_q   <= timer_d;
            btn_lat_q <= btn_lat_d;
            pad_q     <= pad_d;
        end
    end

    assign pad.pad_out = pad_q;
    assign pad.cyc_dbg = cyc_q;
endmodule
